// File: rtl/seq_comparator.sv
// Sequential magnitude comparator. Compares two WIDTH-bit operands one
// CHUNK-bit slice per cycle, starting at the most significant slice, and
// stops at the first slice that differs.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request a comparison (sampled only while idle)
//   signed_mode  1: two's-complement compare, 0: unsigned compare
//   a, b         operands, captured on the accepting edge
//   busy         high while a comparison is in progress (CMP and DONE)
//   done         one-cycle completion pulse
//   gt, eq, lt   result flags for a>b, a==b, a<b (held until next decision)
//   cycles       number of slice-compare cycles used by the last comparison
module seq_comparator #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 signed_mode,
    input  logic [WIDTH-1:0]                     a,
    input  logic [WIDTH-1:0]                     b,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 gt,
    output logic                                 eq,
    output logic                                 lt,
    output logic [$clog2(WIDTH/CHUNK+1)-1:0]     cycles
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CntW = $clog2(N + 1);

    // Flipping the sign bit of both operands maps two's-complement order
    // onto unsigned order, so the slice compare never needs to know the mode.
    localparam logic [WIDTH-1:0] MsbMask = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCmp,
        StDone
    } state_e;

    state_e                        state_q, state_d;
    logic [N-1:0][CHUNK-1:0]       a_q, a_d;
    logic [N-1:0][CHUNK-1:0]       b_q, b_d;
    logic [IdxW-1:0]               idx_q, idx_d;
    logic [CntW-1:0]               cnt_q, cnt_d;
    logic [CntW-1:0]               cycles_q, cycles_d;
    logic                          gt_q, gt_d;
    logic                          eq_q, eq_d;
    logic                          lt_q, lt_d;

    logic [CHUNK-1:0]              a_slice;
    logic [CHUNK-1:0]              b_slice;
    logic [CntW-1:0]               cnt_inc;

    assign a_slice = a_q[idx_q];
    assign b_slice = b_q[idx_q];
    assign cnt_inc = cnt_q + CntW'(1);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        gt_d     = gt_q;
        eq_d     = eq_q;
        lt_d     = lt_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = signed_mode ? (a ^ MsbMask) : a;
                    b_d     = signed_mode ? (b ^ MsbMask) : b;
                    idx_d   = IdxW'(N - 1);
                    cnt_d   = '0;
                    state_d = StCmp;
                end
            end
            StCmp: begin
                cnt_d = cnt_inc;
                if (a_slice > b_slice) begin
                    gt_d     = 1'b1;
                    eq_d     = 1'b0;
                    lt_d     = 1'b0;
                    cycles_d = cnt_inc;
                    state_d  = StDone;
                end else if (a_slice < b_slice) begin
                    gt_d     = 1'b0;
                    eq_d     = 1'b0;
                    lt_d     = 1'b1;
                    cycles_d = cnt_inc;
                    state_d  = StDone;
                end else if (idx_q == '0) begin
                    gt_d     = 1'b0;
                    eq_d     = 1'b1;
                    lt_d     = 1'b0;
                    cycles_d = cnt_inc;
                    state_d  = StDone;
                end else begin
                    idx_d = idx_q - IdxW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= IdxW'(N - 1);
            cnt_q    <= '0;
            cycles_q <= '0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            gt_q     <= gt_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign gt     = gt_q;
    assign eq     = eq_q;
    assign lt     = lt_q;
    assign cycles = cycles_q;

endmodule

// File: tb/tb_seq_comparator.sv
// Self-checking bench for seq_comparator: directed cases, randomized
// operands against a behavioural model, reset abort, back-to-back starts,
// and a single-slice (CHUNK == WIDTH) instance.
module tb_seq_comparator;

    localparam int W = 32;
    localparam int C = 4;
    localparam int N = W / C;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_mode;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        gt;
    logic        eq;
    logic        lt;
    logic [3:0]  cycles;

    logic        start8;
    logic        sm8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic        gt8;
    logic        eq8;
    logic        lt8;
    logic [0:0]  cycles8;

    int checks   = 0;
    int failures = 0;

    // Last result the DUT is expected to be holding.
    logic [2:0]  last_flags;
    logic [3:0]  last_cyc;

    seq_comparator #(.WIDTH(32), .CHUNK(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .gt          (gt),
        .eq          (eq),
        .lt          (lt),
        .cycles      (cycles)
    );

    seq_comparator #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start8),
        .signed_mode (sm8),
        .a           (a8),
        .b           (b8),
        .busy        (busy8),
        .done        (done8),
        .gt          (gt8),
        .eq          (eq8),
        .lt          (lt8),
        .cycles      (cycles8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: result from plain integer ordering; deciding slice k from
    // the position of the highest differing bit.
    task automatic model(input logic [31:0] x, input logic [31:0] y, input logic sm,
                         output logic [2:0] flags, output int k);
        logic [31:0] d;
        int hi;
        logic g;
        logic e;
        d  = x ^ y;
        hi = -1;
        for (int i = 0; i < W; i++) if (d[i]) hi = i;
        k = (hi < 0) ? N : N - hi / C;
        e = (x == y);
        g = sm ? ($signed(x) > $signed(y)) : (x > y);
        flags = {g, e, !g && !e};
    endtask

    // Entered #1 after the accepting edge; counts edges until done.
    task automatic wait_result(input string tag, input logic [2:0] flags, input int k,
                               input bit disturb);
        int edges;
        edges = 0;
        while (done !== 1'b1 && edges < N + 3) begin
            check({tag, "_hold_flags"}, {29'd0, gt, eq, lt}, {29'd0, last_flags});
            check({tag, "_hold_cycles"}, {28'd0, cycles}, {28'd0, last_cyc});
            if (disturb) begin
                a     = $urandom;
                b     = $urandom;
                start = 1'($urandom_range(0, 1));
                signed_mode = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            edges++;
        end
        if (disturb) start = 1'b0;
        check({tag, "_latency"}, edges, k);
        check({tag, "_flags"}, {29'd0, gt, eq, lt}, {29'd0, flags});
        check({tag, "_cycles"}, {28'd0, cycles}, k);
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
        last_flags = flags;
        last_cyc   = 4'(k);
    endtask

    task automatic do_cmp(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic sm, input bit disturb);
        logic [2:0] flags;
        int k;
        model(av, bv, sm, flags, k);
        @(negedge clk);
        a = av;
        b = bv;
        signed_mode = sm;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!disturb) start = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_result(tag, flags, k, disturb);
        @(posedge clk);
        #1;
        check({tag, "_done_clr"}, {31'd0, done}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic cmp8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic sm);
        logic g;
        logic e;
        e = (av == bv);
        g = sm ? ($signed(av) > $signed(bv)) : (av > bv);
        @(negedge clk);
        a8 = av;
        b8 = bv;
        sm8 = sm;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        check({tag, "_busy"}, {31'd0, busy8}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_done"}, {31'd0, done8}, 32'd1);
        check({tag, "_flags"}, {29'd0, gt8, eq8, lt8}, {29'd0, g, e, !g && !e});
        check({tag, "_cycles"}, {31'd0, cycles8}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_done_clr"}, {31'd0, done8}, 32'd0);
    endtask

    initial begin
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] mask;
        logic [2:0]  flags;
        logic [31:0] ba [3];
        logic [31:0] bb [3];
        logic        bs [3];
        int          k;
        int          s;

        rst_n = 1'b1;
        start = 1'b1;
        signed_mode = 1'b0;
        a = 32'hDEADBEEF;
        b = 32'h12345678;
        start8 = 1'b0;
        sm8 = 1'b0;
        a8 = '0;
        b8 = '0;
        last_flags = 3'b000;
        last_cyc = 4'd0;

        // Reset with start held high: nothing may be captured.
        #2 rst_n = 1'b0;
        #1;
        check("rst_outputs", {24'd0, busy, done, gt, eq, lt, cycles}, 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_start_ignored", {31'd0, busy}, 32'd0);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        do_cmp("msb_gt", 32'hF000_0000, 32'h0FFF_FFFF, 1'b0, 1'b0);
        do_cmp("equal", 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
        do_cmp("signed_lt", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
        do_cmp("unsigned_gt", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        do_cmp("lsb_lt_disturb", 32'h0000_0005, 32'h0000_0006, 1'b0, 1'b1);
        do_cmp("signed_neg_eq", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        do_cmp("signed_min_lt", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);

        // Random operands, sharing a random number of leading bits.
        for (int i = 0; i < 40; i++) begin
            av = $urandom;
            s = $urandom_range(0, 32);
            mask = (s == 32) ? 32'hFFFF_FFFF : ((32'd1 << s) - 32'd1);
            bv = av ^ ($urandom & mask);
            do_cmp("rand", av, bv, 1'($urandom_range(0, 1)), bit'(i % 4 == 0));
        end

        // Reset during the 4th slice-compare cycle aborts the comparison.
        @(negedge clk);
        a = 32'h0000_0005;
        b = 32'h0000_0006;
        signed_mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_outputs", {24'd0, busy, done, gt, eq, lt, cycles}, 32'd0);
        start = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("abort_no_done", {30'd0, busy, done}, 32'd0);
        end
        last_flags = 3'b000;
        last_cyc = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        a = 32'h0ABC_0000;
        b = 32'h0ABD_0000;
        start = 1'b1;
        model(a, b, 1'b0, flags, k);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("post_rst_accept", {31'd0, busy}, 32'd1);
        wait_result("post_rst", flags, k, 1'b0);
        @(posedge clk);
        #1;

        // Back-to-back with start held high.
        ba[0] = 32'h0000_0010; bb[0] = 32'h0000_0001; bs[0] = 1'b0;
        ba[1] = 32'hCAFE_F00D; bb[1] = 32'hCAFE_F00D; bs[1] = 1'b1;
        ba[2] = 32'hF000_0000; bb[2] = 32'h1000_0000; bs[2] = 1'b1;
        @(negedge clk);
        a = ba[0];
        b = bb[0];
        signed_mode = bs[0];
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            model(ba[i], bb[i], bs[i], flags, k);
            check("b2b_busy", {31'd0, busy}, 32'd1);
            wait_result("b2b", flags, k, 1'b0);
            if (i < 2) begin
                a = ba[i+1];
                b = bb[i+1];
                signed_mode = bs[i+1];
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            check("b2b_idle", {30'd0, busy, done}, 32'd0);
            if (i < 2) begin
                @(posedge clk);
                #1;
            end
        end

        // Single-slice instance: always one compare cycle.
        cmp8("n1_gt", 8'h80, 8'h7F, 1'b0);
        cmp8("n1_lt", 8'h80, 8'h7F, 1'b1);
        cmp8("n1_eq", 8'h5A, 8'h5A, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cmp8("n1_rand", 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
